// File: rtl/fetch_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : fetch_decode_queue
//  Purpose  : Fetch-to-decode instruction FIFO with j/jal decode on entry and
//             a one-cycle redirect pulse back to fetch. Optional MIPS branch
//             delay slot handling is enabled by defining DELAY_SLOT_EN.
//  Revision : 1.0 - initial release
// ============================================================================
module fetch_decode_queue #(
    parameter int         DEPTH  = 4,
    parameter int         AW     = 2,
    parameter logic [5:0] J_OP   = 6'b000010,
    parameter logic [5:0] JAL_OP = 6'b000011
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic [31:0]   in_pc,
    input  logic [31:0]   in_instr,
    output logic          in_ready,
    output logic          out_valid,
    output logic [31:0]   out_pc,
    output logic [31:0]   out_instr,
    input  logic          out_ready,
    input  logic          flush,
    output logic          redirect,
    output logic [31:0]   redirect_target,
    output logic [AW:0]   count
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_REDIR     = 2'd1,
        S_SLOT_WAIT = 2'd2
    } state_t;

    localparam logic [AW:0] c_FULL = (AW+1)'(DEPTH);

    state_t        r_state;
    logic [31:0]   r_pc_mem    [DEPTH];
    logic [31:0]   r_instr_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          r_redirect;
    logic [31:0]   r_target;

    logic          w_push;
    logic          w_pop;
    logic          w_is_jump;
    logic [31:0]   w_pc4;
    logic [31:0]   w_target;
    logic          w_unused_pc4;

    assign in_ready  = (r_count < c_FULL) | (r_state == S_REDIR);
    assign out_valid = (r_count != '0);
    assign out_pc    = r_pc_mem[r_rd_ptr];
    assign out_instr = r_instr_mem[r_rd_ptr];
    assign count     = r_count;

    // Wrong-path words seen while redirecting are accepted but never stored.
    assign w_push    = in_valid & in_ready & (r_state != S_REDIR) & ~flush;
    assign w_pop     = out_valid & out_ready & ~flush;

    assign w_is_jump    = (in_instr[31:26] == J_OP) | (in_instr[31:26] == JAL_OP);
    assign w_pc4        = in_pc + 32'd4;
    assign w_target     = {w_pc4[31:28], in_instr[25:0], 2'b00};
    assign w_unused_pc4 = ^w_pc4[27:0];

    // A redirect registered for a flushed cycle must not reach fetch.
    assign redirect        = r_redirect & ~flush;
    assign redirect_target = r_target;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]    <= in_pc;
            r_instr_mem[r_wr_ptr] <= in_instr;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_redirect <= 1'b0;
            r_target   <= '0;
        end else if (flush) begin
            r_state    <= S_IDLE;
            r_redirect <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_redirect <= 1'b0;
                    if (w_push && w_is_jump) begin
                        r_target <= w_target;
`ifdef DELAY_SLOT_EN
                        r_state  <= S_SLOT_WAIT;
`else
                        r_state    <= S_REDIR;
                        r_redirect <= 1'b1;
`endif
                    end
                end
                S_REDIR: begin
                    r_state    <= S_IDLE;
                    r_redirect <= 1'b0;
                end
`ifdef DELAY_SLOT_EN
                // The slot word is stored as plain data, even if it is a jump.
                S_SLOT_WAIT: begin
                    r_redirect <= 1'b0;
                    if (w_push) begin
                        r_state    <= S_REDIR;
                        r_redirect <= 1'b1;
                    end
                end
`endif
                default: begin
                    r_state    <= S_IDLE;
                    r_redirect <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_decode_queue.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fetch_decode_queue
//  Purpose  : Directed table-driven bench for fetch_decode_queue, plus
//             hand-written jump, redirect, flush and reset sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fetch_decode_queue;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [31:0] in_pc;
    logic [31:0] in_instr;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_pc;
    logic [31:0] out_instr;
    logic        out_ready;
    logic        flush;
    logic        redirect;
    logic [31:0] redirect_target;
    logic [2:0]  count;

    int n_checks;
    int n_errors;

    fetch_decode_queue dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_pc           (in_pc),
        .in_instr        (in_instr),
        .in_ready        (in_ready),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_instr       (out_instr),
        .out_ready       (out_ready),
        .flush           (flush),
        .redirect        (redirect),
        .redirect_target (redirect_target),
        .count           (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        ordy;
        logic        fl;
        logic [2:0]  e_count;
        logic        e_rdy;
        logic        e_ov;
        logic [31:0] e_instr;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change on the falling edge; outputs are sampled 1 ns later.
    task automatic step(input logic iv, input logic [31:0] pc, input logic [31:0] instr,
                        input logic ordy, input logic fl);
        @(negedge clk);
        in_valid  = iv;
        in_pc     = pc;
        in_instr  = instr;
        out_ready = ordy;
        flush     = fl;
        #1;
    endtask

    function automatic logic [31:0] dw(input int k);
        return 32'h1000_0000 + 32'(k);
    endfunction

    function automatic logic [31:0] pw(input int k);
        return 32'h0000_0100 + 32'(4 * k);
    endfunction

    task automatic jump_check(input string name, input logic [31:0] pc,
                              input logic [31:0] instr, input logic [31:0] exp_tgt);
        step(1'b1, pc, instr, 1'b0, 1'b0);
        chk({name, "_redir_early"}, 32'(redirect), 32'd0);
`ifdef DELAY_SLOT_EN
        step(1'b1, pc + 32'd4, 32'h0, 1'b0, 1'b0);
        chk({name, "_redir_slot"}, 32'(redirect), 32'd0);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk({name, "_redir"}, 32'(redirect), 32'd1);
        chk({name, "_target"}, redirect_target, exp_tgt);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk({name, "_cleared"}, 32'(count), 32'd0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        rst       = 1'b0;
        in_valid  = 1'b0;
        in_pc     = '0;
        in_instr  = '0;
        out_ready = 1'b0;
        flush     = 1'b0;

        //          iv   pc      instr    ordy  fl  cnt  rdy  ov   head
        tbl[0]  = '{1'b1, pw(1), dw(1), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
        tbl[1]  = '{1'b1, pw(2), dw(2), 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, dw(1)};
        tbl[2]  = '{1'b1, pw(3), dw(3), 1'b0, 1'b0, 3'd2, 1'b1, 1'b1, dw(1)};
        tbl[3]  = '{1'b1, pw(4), dw(4), 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, dw(1)};
        tbl[4]  = '{1'b1, pw(5), dw(5), 1'b0, 1'b0, 3'd4, 1'b0, 1'b1, dw(1)};
        tbl[5]  = '{1'b1, pw(5), dw(5), 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, dw(1)};
        tbl[6]  = '{1'b1, pw(5), dw(5), 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, dw(2)};
        tbl[7]  = '{1'b1, pw(6), dw(6), 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, dw(3)};
        tbl[8]  = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, dw(3)};
        tbl[9]  = '{1'b1, pw(7), dw(7), 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, dw(4)};
        tbl[10] = '{1'b1, pw(8), dw(8), 1'b0, 1'b0, 3'd3, 1'b1, 1'b1, dw(5)};
        tbl[11] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd4, 1'b0, 1'b1, dw(5)};
        tbl[12] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd3, 1'b1, 1'b1, dw(6)};
        tbl[13] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd2, 1'b1, 1'b1, dw(7)};
        tbl[14] = '{1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 3'd1, 1'b1, 1'b1, dw(8)};
        tbl[15] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
        tbl[16] = '{1'b1, pw(1), dw(1), 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};
        tbl[17] = '{1'b1, pw(2), dw(2), 1'b0, 1'b0, 3'd1, 1'b1, 1'b1, dw(1)};
        tbl[18] = '{1'b1, pw(3), dw(3), 1'b0, 1'b1, 3'd2, 1'b1, 1'b1, dw(1)};
        tbl[19] = '{1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 3'd0, 1'b1, 1'b0, 32'h0};

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_redirect", 32'(redirect), 32'd0);
        chk("rst_target", redirect_target, 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b1;

        // Asynchronous reset in the middle of a stream
        step(1'b1, pw(1), dw(1), 1'b0, 1'b0);
        step(1'b1, pw(2), dw(2), 1'b0, 1'b0);
        step(1'b1, pw(3), dw(3), 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("mid_count_before", 32'(count), 32'd3);
        rst = 1'b0;
        #1;
        chk("mid_rst_count", 32'(count), 32'd0);
        chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
        chk("mid_rst_redirect", 32'(redirect), 32'd0);
        #1;
        rst = 1'b1;

        // FIFO fill, full behaviour, wrap ordering and flush
        for (int i = 0; i < 20; i++) begin
            step(tbl[i].iv, tbl[i].pc, tbl[i].instr, tbl[i].ordy, tbl[i].fl);
            chk($sformatf("tbl%0d_count", i), 32'(count), 32'(tbl[i].e_count));
            chk($sformatf("tbl%0d_in_ready", i), 32'(in_ready), 32'(tbl[i].e_rdy));
            chk($sformatf("tbl%0d_out_valid", i), 32'(out_valid), 32'(tbl[i].e_ov));
            chk($sformatf("tbl%0d_redirect", i), 32'(redirect), 32'd0);
            if (tbl[i].e_ov) begin
                chk($sformatf("tbl%0d_out_instr", i), out_instr, tbl[i].e_instr);
                chk($sformatf("tbl%0d_out_pc", i), out_pc,
                    32'h100 + ((tbl[i].e_instr - 32'h1000_0000) << 2));
            end
        end

        // Jump: redirect one cycle after it takes effect; wrong-path word dropped
        step(1'b1, 32'h0040_0010, 32'h0810_0040, 1'b0, 1'b0);
        chk("j_redir_early", 32'(redirect), 32'd0);
`ifdef DELAY_SLOT_EN
        step(1'b1, 32'h0040_0014, 32'h0000_0000, 1'b0, 1'b0);
        chk("j_redir_slot", 32'(redirect), 32'd0);
        chk("j_count_slot", 32'(count), 32'd1);
        step(1'b1, 32'h0040_0018, 32'h0800_0123, 1'b0, 1'b0);
        chk("j_redir", 32'(redirect), 32'd1);
        chk("j_target", redirect_target, 32'h0040_0100);
        chk("j_count_redir", 32'(count), 32'd2);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("j_redir_after", 32'(redirect), 32'd0);
        chk("j_count_after", 32'(count), 32'd2);
`else
        step(1'b1, 32'h0040_0014, 32'h0800_0123, 1'b0, 1'b0);
        chk("j_redir", 32'(redirect), 32'd1);
        chk("j_target", redirect_target, 32'h0040_0100);
        chk("j_count_redir", 32'(count), 32'd1);
        chk("j_in_ready", 32'(in_ready), 32'd1);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("j_redir_after", 32'(redirect), 32'd0);
        chk("j_count_after", 32'(count), 32'd1);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("j_head_instr", out_instr, 32'h0810_0040);
        chk("j_head_pc", out_pc, 32'h0040_0010);
`ifdef DELAY_SLOT_EN
        step(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        chk("j_slot_instr", out_instr, 32'h0000_0000);
        chk("j_slot_pc", out_pc, 32'h0040_0014);
`endif
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("j_drained", 32'(count), 32'd0);
        chk("j_no_redir", 32'(redirect), 32'd0);

        // Target region taken from pc+4, and jal decode
        jump_check("region", 32'h0FFF_FFFC, 32'h0800_0004, 32'h1000_0010);
        jump_check("jal", 32'h0040_0030, 32'h0C00_0010, 32'h0000_0040);

        // Flush in the cycle after a jump push
        step(1'b1, 32'h0040_0020, 32'h0C00_0010, 1'b0, 1'b0);
        step(1'b1, 32'h0040_0024, dw(9), 1'b0, 1'b1);
        chk("fl_redir_suppressed", 32'(redirect), 32'd0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_count", 32'(count), 32'd0);
        chk("fl_redir_next", 32'(redirect), 32'd0);
        step(1'b1, pw(1), dw(1), 1'b0, 1'b0);
        step(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        chk("fl_idle_redir", 32'(redirect), 32'd0);
        chk("fl_idle_count", 32'(count), 32'd1);
        chk("fl_idle_head", out_instr, dw(1));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
